ofifo_collector: RTL

//  Output FIFO directly downstream of the 8x8 MAC array. It captures the

---
 rtl/ofifo_collector.sv | 89 ++++++++
 1 files changed

// File: rtl/ofifo_collector.sv
// Output FIFO behind the MAC array: one FIFO lane per column de-skews partial sums into aligned rows.
// Optional OFIFO_RELU_EN: clamp negative columns to zero on the way out (storage stays raw).
module ofifo_collector #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int depth   = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [psum_bw*col-1:0]   in,
   input  logic [col-1:0]           wr,
   input  logic                     rd,
   output logic [psum_bw*col-1:0]   out,
   output logic                     out_stb,
   output logic                     o_valid,
   output logic                     o_full,
   output logic                     o_ovf
);

   localparam int AW = $clog2(depth);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [psum_bw-1:0]     mem [col][depth];
   logic [AW:0]            wr_ptr [col];
   logic [AW:0]            rd_ptr;
   logic [col-1:0]         empty;
   logic [col-1:0]         full;
   logic [col-1:0]         wr_acc;
   logic [col-1:0]         wr_drop;
   logic                   pop;
   logic [psum_bw*col-1:0] row;

   // Every lane pops in lockstep, so one shared read pointer stands in for the per-lane ones.
   always_comb begin
      empty   = '0;
      full    = '0;
      wr_acc  = '0;
      wr_drop = '0;
      row     = '0;
      for (int c = 0; c < col; c++) begin
         empty[c] = (wr_ptr[c] == rd_ptr);
         full[c]  = (wr_ptr[c][AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[c][AW] != rd_ptr[AW]);
      end
      o_valid = ~|empty;
      o_full  = |full;
      pop     = rd && o_valid;
      for (int c = 0; c < col; c++) begin
         wr_acc[c]  = wr[c] && (!full[c] || pop);
         wr_drop[c] = wr[c] && full[c] && !pop;
         row[c*psum_bw +: psum_bw] = mem[c][rd_ptr[AW-1:0]];
`ifdef OFIFO_RELU_EN
         if (row[c*psum_bw + psum_bw - 1])
            row[c*psum_bw +: psum_bw] = '0;
`endif
      end
   end

   // Lane storage has no reset; stale entries are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      for (int c = 0; c < col; c++) begin
         if (!reset && wr_acc[c])
            mem[c][wr_ptr[c][AW-1:0]] <= in[c*psum_bw +: psum_bw];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr  <= '0;
         out     <= '0;
         out_stb <= 1'b0;
         o_ovf   <= 1'b0;
         for (int c = 0; c < col; c++)
            wr_ptr[c] <= '0;
      end else begin
         for (int c = 0; c < col; c++) begin
            if (wr_acc[c])
               wr_ptr[c] <= wr_ptr[c] + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            out    <= row;
         end
         out_stb <= pop;
         if (|wr_drop)
            o_ovf <= 1'b1;
      end
   end

endmodule
